// File: rtl/ahb_apb_pkg.sv
// Shared constants, state encoding and strobe helper for the AHB-Lite to APB4 bridge.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {IDLE, WAIT, SETUP, ACCESS, ERR1, ERR2} bridge_state_e;

  // Byte-lane mask for a transfer of 1<<hsize bytes starting at lane lo (up to 8 lanes).
  function automatic logic [7:0] size_to_strb(input logic [2:0] lo, input logic [2:0] hsize);
    logic [7:0] m;
    case (hsize)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << lo;
  endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Combinational slave decode: index field to one-hot select; no hit means decode error.
module apb_slave_decoder #(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  decode_err
);

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
    assign sel[i] = (idx == SEL_W'(i));
  end

  // An index beyond the populated slaves matches no lane.
  assign decode_err = ~|sel;

endmodule

// File: rtl/ahb2apb_bridge_mp.sv
// AHB-Lite to APB4 bridge fanning out to NUM_SLAVES slaves.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without pready.
module ahb2apb_bridge_mp
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  input  logic                         hsel,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [1:0]                   htrans,
  input  logic                         hwrite,
  input  logic [2:0]                   hsize,
  input  logic [DATA_W-1:0]            hwdata,
  input  logic                         hready,
  output logic                         hreadyout,
  output logic                         hresp,
  output logic [DATA_W-1:0]            hrdata,
  output logic [ADDR_W-1:0]            paddr,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [DATA_W-1:0]            pwdata,
  output logic [DATA_W/8-1:0]          pstrb,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic                  write;
    logic [STRB_W-1:0]     strb;
    logic [NUM_SLAVES-1:0] sel;
  } apb_req_t;

  bridge_state_e         st, nxt;
  apb_req_t              req_q;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err, size_err, accept, rdy_s, err_s, tmo;
  logic [DATA_W-1:0]     rd_mux;
  logic [STRB_W-1:0]     strb_w;

  assign accept   = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
  assign size_err = (32'd8 << hsize) > 32'(DATA_W);
  assign strb_w   = STRB_W'(size_to_strb(3'(haddr[OFF_W-1:0]), hsize));

  apb_slave_decoder #(.NUM_SLAVES(NUM_SLAVES), .SEL_W(SEL_W)) u_dec (
    .idx        (haddr[SEL_LSB +: SEL_W]),
    .sel        (dec_sel),
    .decode_err (dec_err)
  );

  // Only the latched slave's response lanes are observed.
  always_comb begin
    rd_mux = '0;
    rdy_s  = 1'b0;
    err_s  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (req_q.sel[i]) begin
        rd_mux = rd_mux | prdata[i*DATA_W +: DATA_W];
        rdy_s  = rdy_s | pready[i];
        err_s  = err_s | pslverr[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)          tmo_cnt <= '0;
    else if (st == ACCESS) tmo_cnt <= tmo_cnt + 1'b1;
    else                   tmo_cnt <= '0;
  end

  // Fires on the last allowed ACCESS cycle so exactly TIMEOUT_CYC cycles are spent waiting.
  assign tmo = (st == ACCESS) && !rdy_s && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt = st;
    case (st)
      IDLE, ERR2: nxt = accept ? ((dec_err | size_err) ? ERR1 : WAIT) : IDLE;
      WAIT:       nxt = SETUP;
      SETUP:      nxt = ACCESS;
      ACCESS: begin
        if (rdy_s)    nxt = err_s ? ERR1 : IDLE;
        else if (tmo) nxt = ERR1;
      end
      ERR1:       nxt = ERR2;
      default:    nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      st     <= IDLE;
      req_q  <= '0;
      pwdata <= '0;
      hrdata <= '0;
    end else begin
      st <= nxt;
      if ((st == IDLE || st == ERR2) && accept) begin
        req_q.addr  <= haddr;
        req_q.write <= hwrite;
        req_q.strb  <= hwrite ? strb_w : '0;
        req_q.sel   <= dec_sel;
      end
      // hwdata is valid in the AHB data phase, which is the WAIT cycle.
      if (st == WAIT && req_q.write) pwdata <= hwdata;
      if (st == ACCESS && rdy_s && !err_s && !req_q.write) hrdata <= rd_mux;
    end
  end

  assign hreadyout = (st == IDLE) || (st == ERR2);
  assign hresp     = (st == ERR1 || st == ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign psel      = (st == SETUP || st == ACCESS) ? req_q.sel : '0;
  assign penable   = (st == ACCESS);
  assign paddr     = req_q.addr;
  assign pwrite    = req_q.write;
  assign pstrb     = req_q.strb;

endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// Directed bench for ahb2apb_bridge_mp: per-cycle expected bus trace plus literal per-transfer results.
module tb_ahb2apb_bridge_mp;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TMO = 8;

  logic            hclk = 1'b0;
  logic            hresetn = 1'b0;
  logic            hsel = 1'b0;
  logic [AW-1:0]   haddr = '0;
  logic [1:0]      htrans = 2'b00;
  logic            hwrite = 1'b0;
  logic [2:0]      hsize = 3'd2;
  logic [DW-1:0]   hwdata = '0;
  logic            hready;
  logic            hreadyout, hresp;
  logic [DW-1:0]   hrdata;
  logic [AW-1:0]   paddr;
  logic [NS-1:0]   psel;
  logic            penable, pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]   pready = '1;
  logic [NS-1:0]   pslverr = '0;

  logic [31:0] rom [NS] = '{32'hCAFEF00D, 32'h0BADF00D, 32'h5555AAAA, 32'h12345678};
  assign prdata = {rom[3], rom[2], rom[1], rom[0]};
  assign hready = hreadyout;

  always #5 hclk = ~hclk;

  ahb2apb_bridge_mp #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS), .SEL_LSB(12), .TIMEOUT_CYC(TMO)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One entry per expected bus cycle; an empty queue means an idle, ready bridge.
  typedef struct packed {
    logic        ro, rs;
    logic [3:0]  sel;
    logic        en;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic        upd;
    logic [31:0] rd;
  } exp_t;

  exp_t        q[$];
  exp_t        ce;
  logic [31:0] m_hrdata = '0;
  int          s_waits = 0;
  bit          s_err = 1'b0;

  // APB slave model: the selected slave holds pready low for s_waits ACCESS cycles.
  initial begin
    int acc;
    acc = 0;
    forever begin
      @(posedge hclk); #1;
      if (|psel && penable) acc++; else acc = 0;
      pready  = ~psel | ((acc > s_waits) ? psel : '0);
      pslverr = s_err ? psel : '0;
    end
  end

  // Compare process.
  initial forever begin
    @(negedge hclk);
    ce = '0;
    ce.ro = 1'b1;
    if (q.size() > 0) ce = q.pop_front();
    chk({hreadyout, hresp, psel, penable} === {ce.ro, ce.rs, ce.sel, ce.en}, "bus_cycle",
        {hreadyout, hresp, psel, penable}, {ce.ro, ce.rs, ce.sel, ce.en});
    if (ce.sel != 4'b0) begin
      chk(paddr === ce.addr, "paddr", paddr, ce.addr);
      chk(pwrite === ce.wr, "pwrite", pwrite, ce.wr);
      chk(pstrb === ce.strb, "pstrb", pstrb, ce.strb);
      if (ce.wr) chk(pwdata === ce.wd, "pwdata", pwdata, ce.wd);
    end
    chk(hrdata === m_hrdata, "hrdata", hrdata, m_hrdata);
    if (ce.upd) m_hrdata = ce.rd;
  end

  typedef struct {
    logic [31:0] a;
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    int          waits;
    bit          err;
    bit          gap;
    int          low;
    bit          resp;
    logic [3:0]  sel;
    logic [3:0]  strb;
    logic [31:0] rd;
  } vec_t;

  // a, wr, sz, wd, waits, err, gap | low, resp, sel seen, strb seen, hrdata after
  vec_t vecs [9] = '{
    '{32'h0000_1004, 1'b1, 3'd2, 32'hDEADBEEF, 0, 1'b0, 1'b1, 3, 1'b0, 4'b0010, 4'hF,    32'h0},
    '{32'h0000_3000, 1'b0, 3'd2, 32'h0,        2, 1'b0, 1'b1, 5, 1'b0, 4'b1000, 4'h0,    32'h12345678},
    '{32'h0000_5000, 1'b1, 3'd2, 32'hA5A50001, 0, 1'b0, 1'b1, 3, 1'b0, 4'b0010, 4'hF,    32'h12345678},
    '{32'h0000_0000, 1'b1, 3'd3, 32'h0,        0, 1'b0, 1'b1, 1, 1'b1, 4'b0000, 4'h0,    32'h12345678},
    '{32'h0000_0000, 1'b0, 3'd2, 32'h0,        1, 1'b1, 1'b1, 5, 1'b1, 4'b0001, 4'h0,    32'h12345678},
    '{32'h0000_2003, 1'b1, 3'd0, 32'h11000000, 0, 1'b0, 1'b0, 3, 1'b0, 4'b0100, 4'b1000, 32'h12345678},
    '{32'h0000_1002, 1'b0, 3'd1, 32'h0,        0, 1'b0, 1'b0, 3, 1'b0, 4'b0010, 4'h0,    32'h0BADF00D},
    '{32'h0000_3006, 1'b1, 3'd1, 32'hBEEF0000, 1, 1'b0, 1'b1, 4, 1'b0, 4'b1000, 4'b1100, 32'h0BADF00D},
    '{32'h0000_2004, 1'b0, 3'd2, 32'h0,        0, 1'b0, 1'b0, 3, 1'b0, 4'b0100, 4'h0,    32'h5555AAAA}
  };

  task automatic xfer(input vec_t v);
    exp_t       e;
    int         low, idx, n_acc;
    bit         derr, tmo;
    logic [3:0] sel_seen, strb_seen;
    if (v.gap) begin @(posedge hclk); #1; end
    s_waits = v.waits;
    s_err   = v.err;
    hsel = 1'b1; haddr = v.a; htrans = 2'b10; hwrite = v.wr; hsize = v.sz;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = v.wd;
    // Expected trace from the protocol rules.
    idx   = int'(v.a[13:12]);
    derr  = (idx >= NS) || ((8 << v.sz) > DW);
    n_acc = v.waits + 1;
    tmo   = 1'b0;
`ifdef APB_TIMEOUT_EN
    if (n_acc > TMO) begin n_acc = TMO; tmo = 1'b1; end
`endif
    e = '0;
    e.addr = v.a; e.wr = v.wr; e.wd = v.wd;
    e.strb = v.wr ? 4'(((1 << (1 << v.sz)) - 1) << v.a[1:0]) : 4'h0;
    if (!derr) begin
      q.push_back(e);
      e.sel = 4'(1 << idx);
      q.push_back(e);
      e.en = 1'b1;
      for (int k = 0; k < n_acc; k++) begin
        if (k == n_acc - 1 && !v.wr && !v.err && !tmo) begin e.upd = 1'b1; e.rd = rom[idx]; end
        q.push_back(e);
      end
    end
    if (derr || v.err || tmo) begin
      e = '0; e.rs = 1'b1;
      q.push_back(e);
      e.ro = 1'b1;
      q.push_back(e);
    end
    low = 0; sel_seen = '0; strb_seen = '0;
    while (!hreadyout && low < 64) begin
      low++;
      if (|psel) begin sel_seen = psel; strb_seen = pstrb; end
      @(posedge hclk); #1;
    end
    chk(low == v.low, "latency", low, v.low);
    chk(hresp === v.resp, "hresp_end", hresp, v.resp);
    chk(sel_seen === v.sel, "psel_seen", sel_seen, v.sel);
    chk(strb_seen === v.strb, "pstrb_seen", strb_seen, v.strb);
    chk(hrdata === v.rd, "hrdata_end", hrdata, v.rd);
  endtask

  initial begin
    exp_t e;
    #7;
    chk(hreadyout === 1'b1, "rst_hreadyout", hreadyout, 1);
    chk(hresp === 1'b0, "rst_hresp", hresp, 0);
    chk(hrdata === '0, "rst_hrdata", hrdata, 0);
    chk(psel === '0, "rst_psel", psel, 0);
    chk(penable === 1'b0, "rst_penable", penable, 0);
    chk(paddr === '0, "rst_paddr", paddr, 0);
    chk(pwrite === 1'b0, "rst_pwrite", pwrite, 0);
    chk(pwdata === '0, "rst_pwdata", pwdata, 0);
    chk(pstrb === '0, "rst_pstrb", pstrb, 0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    // BUSY and IDLE transfers must be ignored.
    hsel = 1'b1; haddr = 32'h1000; htrans = 2'b01;
    @(posedge hclk); #1;
    htrans = 2'b00;
    @(posedge hclk); #1;
    hsel = 1'b0;
    foreach (vecs[i]) xfer(vecs[i]);

    // Reset in the second ACCESS cycle of a stalled read.
    @(posedge hclk); #1;
    s_waits = 100; s_err = 1'b0;
    hsel = 1'b1; haddr = 32'h2000; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    e = '0; q.push_back(e);
    e.sel = 4'b0100; e.addr = 32'h2000; q.push_back(e);
    e.en = 1'b1; q.push_back(e);
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    @(posedge hclk); #1;
    chk(penable === 1'b1 && psel === 4'b0100, "pre_reset_access", {psel, penable}, {4'b0100, 1'b1});
    #2;
    hresetn = 1'b0;
    m_hrdata = '0;
    #1;
    chk(psel === '0, "rst_mid_psel", psel, 0);
    chk(penable === 1'b0, "rst_mid_penable", penable, 0);
    chk(hreadyout === 1'b1, "rst_mid_hreadyout", hreadyout, 1);
    chk(hresp === 1'b0, "rst_mid_hresp", hresp, 0);
    chk(hrdata === '0, "rst_mid_hrdata", hrdata, 0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    s_waits = 0;
    xfer('{32'h0000_1000, 1'b0, 3'd2, 32'h0, 0, 1'b0, 1'b1, 3, 1'b0, 4'b0010, 4'h0, 32'h0BADF00D});
`ifdef APB_TIMEOUT_EN
    xfer('{32'h0000_2000, 1'b1, 3'd2, 32'h77, 20, 1'b0, 1'b1, 11, 1'b1, 4'b0100, 4'hF, 32'h0BADF00D});
`endif
    repeat (3) @(posedge hclk);
    #1;
    chk(q.size() == 0, "trace_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
